// File: rtl/wb_regfile.sv
// Writeback stage: selects the retiring value, commits it to a 32x32 register file, serves two ID read ports.
// Latency: commit on 1 edge, reads combinational with write-through bypass; no backpressure (accepts every cycle).
module wb_regfile #(
  parameter logic [31:0] LINK_OFFSET = 32'd4,
  parameter logic [31:0] SP_INIT     = 32'h0000_07fc,
  parameter logic [31:0] GP_INIT     = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_WB,
  input  logic [1:0]  MemtoReg_WB,
  input  logic [4:0]  Rw_WB,
  input  logic [31:0] ReadData_WB,
  input  logic [31:0] ALUOut_WB,
  input  logic [31:0] PC_WB,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic [31:0] write_count,
  output logic [4:0]  last_wb_addr,
  output logic [31:0] last_wb_data
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] dat;
  } wb_rec_t;

  logic [31:0] regs [32];
  wb_rec_t     last_wb;

  always_comb begin
    wb_data = ALUOut_WB;
    case (MemtoReg_WB)
      2'd1:    wb_data = ReadData_WB;
      2'd2:    wb_data = PC_WB + LINK_OFFSET;
      default: wb_data = ALUOut_WB;
    endcase
  end

  assign wb_en = RegWrite_WB & (Rw_WB != 5'd0);

  // regs[0] is held at zero and never written; reads of r0 are also forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      regs[28] <= GP_INIT;
      regs[29] <= SP_INIT;
    end else if (wb_en) begin
      regs[Rw_WB] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count <= 32'd0;
      last_wb     <= '0;
    end else if (wb_en) begin
      write_count <= write_count + 32'd1;
      last_wb     <= '{addr: Rw_WB, dat: wb_data};
    end
  end

  assign last_wb_addr = last_wb.addr;
  assign last_wb_data = last_wb.dat;

  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (wb_en && (rs_addr == Rw_WB)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (wb_en && (rt_addr == Rw_WB)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset values, source select, bypass, r0, link wrap, reset mid-stream.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite_WB = 1'b0;
  logic [1:0]  MemtoReg_WB = 2'd0;
  logic [4:0]  Rw_WB = 5'd0;
  logic [31:0] ReadData_WB = 32'd0;
  logic [31:0] ALUOut_WB = 32'd0;
  logic [31:0] PC_WB = 32'd0;
  logic [4:0]  rs_addr = 5'd0;
  logic [4:0]  rt_addr = 5'd0;
  logic [31:0] rs_data, rt_data, wb_data, write_count, last_wb_data;
  logic        wb_en;
  logic [4:0]  last_wb_addr;

  int n_cmp = 0;
  int n_bad = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .Rw_WB(Rw_WB), .ReadData_WB(ReadData_WB), .ALUOut_WB(ALUOut_WB), .PC_WB(PC_WB),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_en(wb_en), .write_count(write_count),
    .last_wb_addr(last_wb_addr), .last_wb_data(last_wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  task automatic edge_pass();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b1;
    #1;
    rs_addr = 5'd1; rt_addr = 5'd28;
    #1;
    n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL reset_r1: got %h want %h", rs_data, 32'd0); end
    n_cmp++; if (rt_data !== 32'h0000_1800) begin n_bad++; $display("FAIL reset_r28: got %h want %h", rt_data, 32'h0000_1800); end
    rs_addr = 5'd29;
    #1;
    n_cmp++; if (rs_data !== 32'h0000_07fc) begin n_bad++; $display("FAIL reset_r29: got %h want %h", rs_data, 32'h0000_07fc); end
    n_cmp++; if (write_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h want %h", write_count, 32'd0); end
    n_cmp++; if (last_wb_addr !== 5'd0 || last_wb_data !== 32'd0) begin n_bad++; $display("FAIL reset_last: got %h/%h want 0/0", last_wb_addr, last_wb_data); end
    // A write presented while reset is high must not commit.
    RegWrite_WB = 1'b1; Rw_WB = 5'd1; ALUOut_WB = 32'h99;
    edge_pass();
    @(negedge clk);
    RegWrite_WB = 1'b0; rs_addr = 5'd1;
    #1;
    n_cmp++; if (rs_data !== 32'd0 || write_count !== 32'd0) begin n_bad++; $display("FAIL reset_hold: got r1=%h cnt=%h want 0/0", rs_data, write_count); end
    reset = 1'b0;
  endtask

  task automatic test_source_select();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h104; exp_v[3] = 32'h11;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      RegWrite_WB = 1'b1; Rw_WB = 5'd8; ALUOut_WB = 32'h11; ReadData_WB = 32'h22;
      PC_WB = 32'h100; MemtoReg_WB = 2'(m); rs_addr = 5'd8;
      #1;
      n_cmp++; if (wb_data !== exp_v[m]) begin n_bad++; $display("FAIL sel_wb_data[%0d]: got %h want %h", m, wb_data, exp_v[m]); end
      edge_pass();
      RegWrite_WB = 1'b0;
      #1;
      n_cmp++; if (rs_data !== exp_v[m]) begin n_bad++; $display("FAIL sel_r8[%0d]: got %h want %h", m, rs_data, exp_v[m]); end
      n_cmp++; if (write_count !== 32'(m + 1)) begin n_bad++; $display("FAIL sel_count[%0d]: got %0d want %0d", m, write_count, m + 1); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    RegWrite_WB = 1'b1; Rw_WB = 5'd5; ALUOut_WB = 32'hdead_beef; MemtoReg_WB = 2'd0;
    rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    n_cmp++; if (rs_data !== 32'hdead_beef || rt_data !== 32'hdead_beef) begin n_bad++; $display("FAIL bypass_hit: got %h/%h want deadbeef", rs_data, rt_data); end
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin n_bad++; $display("FAIL bypass_off: got %h/%h want 0/0", rs_data, rt_data); end
    edge_pass();
    n_cmp++; if (write_count !== 32'd4) begin n_bad++; $display("FAIL bypass_nocommit: got %0d want 4", write_count); end
    @(negedge clk);
    RegWrite_WB = 1'b1;
    edge_pass();
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'hdead_beef || write_count !== 32'd5) begin n_bad++; $display("FAIL bypass_commit: got r5=%h cnt=%0d want deadbeef/5", rs_data, write_count); end
  endtask

  task automatic test_r0();
    @(negedge clk);
    RegWrite_WB = 1'b1; Rw_WB = 5'd0; ALUOut_WB = 32'hffff_ffff; MemtoReg_WB = 2'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("FAIL r0_wb_en: got %b want 0", wb_en); end
    n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL r0_pre: got %h want 0", rs_data); end
    edge_pass();
    n_cmp++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin n_bad++; $display("FAIL r0_post: got %h/%h want 0/0", rs_data, rt_data); end
    n_cmp++; if (write_count !== 32'd5 || last_wb_addr !== 5'd5 || last_wb_data !== 32'hdead_beef) begin
      n_bad++; $display("FAIL r0_state: got cnt=%0d addr=%0d data=%h want 5/5/deadbeef", write_count, last_wb_addr, last_wb_data);
    end
    RegWrite_WB = 1'b0;
  endtask

  task automatic test_link_wrap();
    @(negedge clk);
    RegWrite_WB = 1'b1; Rw_WB = 5'd31; ALUOut_WB = 32'h1234; MemtoReg_WB = 2'd0;
    edge_pass();
    @(negedge clk);
    MemtoReg_WB = 2'd2; PC_WB = 32'hffff_fffc; rs_addr = 5'd31;
    #1;
    n_cmp++; if (wb_data !== 32'd0) begin n_bad++; $display("FAIL link_wb_data: got %h want 0", wb_data); end
    edge_pass();
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL link_r31: got %h want 0", rs_data); end
    n_cmp++; if (last_wb_addr !== 5'd31 || last_wb_data !== 32'd0 || write_count !== 32'd7) begin
      n_bad++; $display("FAIL link_state: got addr=%0d data=%h cnt=%0d want 31/0/7", last_wb_addr, last_wb_data, write_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    RegWrite_WB = 1'b1; Rw_WB = 5'd3; ALUOut_WB = 32'h55; MemtoReg_WB = 2'd0;
    rs_addr = 5'd3; rt_addr = 5'd28;
    edge_pass();
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'h55) begin n_bad++; $display("FAIL mid_r3_pre: got %h want 55", rs_data); end
    @(negedge clk);
    RegWrite_WB = 1'b1; ALUOut_WB = 32'h66;
    #1;
    reset = 1'b1;
    #1;
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'd0 || rt_data !== 32'h0000_1800 || write_count !== 32'd0) begin
      n_bad++; $display("FAIL mid_reset: got r3=%h r28=%h cnt=%0d want 0/1800/0", rs_data, rt_data, write_count);
    end
    RegWrite_WB = 1'b1;
    #1;
    reset = 1'b0;
    edge_pass();
    RegWrite_WB = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'h66 || write_count !== 32'd1 || last_wb_addr !== 5'd3) begin
      n_bad++; $display("FAIL mid_post: got r3=%h cnt=%0d addr=%0d want 66/1/3", rs_data, write_count, last_wb_addr);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    RegWrite_WB = 1'b1; MemtoReg_WB = 2'd1; Rw_WB = 5'd10; ReadData_WB = 32'ha1;
    edge_pass();
    Rw_WB = 5'd11; ReadData_WB = 32'hb2;
    edge_pass();
    RegWrite_WB = 1'b0; rs_addr = 5'd10; rt_addr = 5'd11;
    #1;
    n_cmp++; if (rs_data !== 32'ha1 || rt_data !== 32'hb2) begin n_bad++; $display("FAIL b2b_regs: got %h/%h want a1/b2", rs_data, rt_data); end
    n_cmp++; if (write_count !== 32'd3 || last_wb_data !== 32'hb2) begin n_bad++; $display("FAIL b2b_state: got cnt=%0d data=%h want 3/b2", write_count, last_wb_data); end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_bypass();
    test_r0();
    test_link_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
